multdiv_issue_ctrl: RTL and testbench

Pipeline-side initiator for the shared multiply/divide unit. Accepts a MULT/DIV instruction from the execute stage, latches the operands, issues the one-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, and stalls the pipeline until `data_resultRDY` arrives. It then captures the result or exception and presents a single-cycle writeback to the register file, redirecting exceptions to the status register.

---
 rtl/multdiv_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_multdiv_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall controller for the shared multiply/divide unit: latch, pulse, guard, wait, writeback.
// Optional watchdog on the WAIT state is enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 48,
  parameter int unsigned STATUS_REG     = 30
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_WB
  } state_t;

  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;
  localparam logic [4:0]  STATUS_RD = 5'(STATUS_REG);

  state_t     r_state;
  logic       r_is_div;
  logic [4:0] r_rd;
  logic       w_busy;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [31:0] EXC_TIMEOUT = 32'd6;
  localparam logic [5:0]  CNT_LAST    = 6'(TIMEOUT_CYCLES - 1);
  logic [5:0] r_cnt;
`endif

  assign w_busy = (r_state == S_ISSUE) || (r_state == S_GUARD) || (r_state == S_WAIT);
  assign stall  = ((r_state == S_IDLE) && issue_valid) || w_busy;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_is_div      <= 1'b0;
      r_rd          <= '0;
      ctrl_MULT     <= 1'b0;
      ctrl_DIV      <= 1'b0;
      data_operandA <= '0;
      data_operandB <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exception  <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
      r_cnt         <= '0;
`endif
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (issue_valid) begin
            data_operandA <= issue_opA;
            data_operandB <= issue_opB;
            r_is_div      <= issue_is_div;
            r_rd          <= issue_rd;
            // Pulse is registered on acceptance so it is high exactly during ISSUE.
            ctrl_MULT     <= ~issue_is_div;
            ctrl_DIV      <= issue_is_div;
            r_state       <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_GUARD;
        S_GUARD: begin
          r_state <= S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (data_resultRDY) begin
            wb_valid <= 1'b1;
            r_state  <= S_WB;
            if (data_exception) begin
              wb_rd        <= STATUS_RD;
              wb_data      <= r_is_div ? EXC_DIV : EXC_MULT;
              wb_exception <= 1'b1;
            end else begin
              wb_rd        <= r_rd;
              wb_data      <= data_result;
              wb_exception <= 1'b0;
            end
          end
`ifdef MULTDIV_TIMEOUT_EN
          else if (r_cnt == CNT_LAST) begin
            wb_valid     <= 1'b1;
            wb_rd        <= STATUS_RD;
            wb_data      <= EXC_TIMEOUT;
            wb_exception <= 1'b1;
            r_state      <= S_WB;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
`endif
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl; writeback expectations flow through a scoreboard queue.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        issue_valid, issue_is_div;
  logic [31:0] issue_opA, issue_opB;
  logic [4:0]  issue_rd;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall, wb_valid, wb_exception;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
  } wb_t;

  wb_t         sb[$];
  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_b = '0;

  always #5 clock = ~clock;

  multdiv_issue_ctrl #(.TIMEOUT_CYCLES(48), .STATUS_REG(30)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .issue_valid    (issue_valid),
    .issue_is_div   (issue_is_div),
    .issue_opA      (issue_opA),
    .issue_opB      (issue_opB),
    .issue_rd       (issue_rd),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb();
    wb_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL sb_underflow: observed writeback expected none");
    end else begin
      e = sb.pop_front();
      check("wb_rd", 32'(wb_rd), 32'(e.rd));
      check("wb_data", wb_data, e.data);
      check("wb_exc", 32'(wb_exception), 32'(e.exc));
    end
  endtask

  task automatic drive_junk(input logic is_div);
    issue_valid  = 1'b1;
    issue_is_div = ~is_div;
    issue_opA    = $urandom;
    issue_opB    = $urandom;
    issue_rd     = 5'($urandom);
  endtask

  // Called at an IDLE negedge; returns at the IDLE negedge after writeback.
  // RDY is raised in cycle 'lat' counting the ISSUE cycle as 0; RDY is left untouched
  // through ISSUE/GUARD so a stale high level from the previous op can be exercised.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int unsigned lat,
                        input logic [31:0] res, input logic exc, input logic keep_rdy);
    wb_t e;
    check("opA_hold", data_operandA, prev_a);
    check("opB_hold", data_operandB, prev_b);
    issue_valid  = 1'b1;
    issue_is_div = is_div;
    issue_opA    = a;
    issue_opB    = b;
    issue_rd     = rd;
    #1 check("stall_req", 32'(stall), 32'd1);
    e.rd   = exc ? 5'd30 : rd;
    e.data = exc ? (is_div ? 32'd5 : 32'd4) : res;
    e.exc  = exc;
    sb.push_back(e);
    prev_a = a;
    prev_b = b;
    for (int unsigned i = 0; i <= lat; i++) begin
      @(negedge clock);
      check("pulse_mult", 32'(ctrl_MULT), 32'((i == 0) && !is_div));
      check("pulse_div", 32'(ctrl_DIV), 32'((i == 0) && is_div));
      check("stall_busy", 32'(stall), 32'd1);
      check("wb_early", 32'(wb_valid), 32'd0);
      check("opA_live", data_operandA, a);
      check("opB_live", data_operandB, b);
      drive_junk(is_div);
      if (i == lat) begin
        data_resultRDY = 1'b1;
        data_result    = res;
        data_exception = exc;
      end else if (i >= 2) begin
        data_resultRDY = 1'b0;
        data_result    = $urandom;
        data_exception = 1'b1;
      end
    end
    @(negedge clock);
    check("wb_valid", 32'(wb_valid), 32'd1);
    check("stall_wb", 32'(stall), 32'd0);
    check_wb();
    data_resultRDY = keep_rdy;
    data_exception = 1'b0;
    drive_junk(is_div);
    @(negedge clock);
    issue_valid = 1'b0;
    #1;
    check("wb_once", 32'(wb_valid), 32'd0);
    check("stall_idle", 32'(stall), 32'd0);
    check("opA_after", data_operandA, a);
  endtask

  initial begin
    reset_n        = 1'b0;
    issue_valid    = 1'b0;
    issue_is_div   = 1'b0;
    issue_opA      = '0;
    issue_opB      = '0;
    issue_rd       = '0;
    data_result    = '0;
    data_exception = 1'b0;
    data_resultRDY = 1'b0;

    #3;
    check("rst_mult", 32'(ctrl_MULT), 32'd0);
    check("rst_div", 32'(ctrl_DIV), 32'd0);
    check("rst_opA", data_operandA, 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wbd", wb_data, 32'd0);
    check("rst_stall0", 32'(stall), 32'd0);
    issue_valid = 1'b1;
    #1 check("rst_stall1", 32'(stall), 32'd1);
    issue_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b0, 32'd7, 32'd6, 5'd3, 17, 32'd42, 1'b0, 1'b0);
    run_op(1'b1, 32'd10, 32'd0, 5'd9, 5, 32'hdead_beef, 1'b1, 1'b0);
    run_op(1'b0, 32'h1234, 32'h10, 5'd12, 3, 32'h12340, 1'b0, 1'b1);
    run_op(1'b1, 32'd100, 32'd7, 5'd5, 2, 32'd14, 1'b0, 1'b0);
    run_op(1'b0, 32'd3, 32'd3, 5'd0, 4, 32'd9, 1'b0, 1'b0);
    run_op(1'b0, 32'hffff_ffff, 32'hffff_ffff, 5'd7, 6, 32'd1, 1'b1, 1'b0);

    // Reset in the middle of WAIT: everything clears at once, no writeback follows.
    issue_valid  = 1'b1;
    issue_is_div = 1'b0;
    issue_opA    = 32'd11;
    issue_opB    = 32'd13;
    issue_rd     = 5'd20;
    repeat (4) @(negedge clock);
    issue_valid = 1'b0;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_opA", data_operandA, 32'd0);
    check("arst_opB", data_operandB, 32'd0);
    check("arst_wbrd", 32'(wb_rd), 32'd0);
    check("arst_wbd", wb_data, 32'd0);
    check("arst_wbe", 32'(wb_exception), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    prev_a  = '0;
    prev_b  = '0;
    data_resultRDY = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("post_rst_wbv", 32'(wb_valid), 32'd0);
      check("post_rst_mult", 32'(ctrl_MULT), 32'd0);
    end
    data_resultRDY = 1'b0;
    run_op(1'b0, 32'd5, 32'd5, 5'd4, 3, 32'd25, 1'b0, 1'b0);

`ifdef MULTDIV_TIMEOUT_EN
    begin
      wb_t e;
      check("to_opA_hold", data_operandA, prev_a);
      issue_valid  = 1'b1;
      issue_is_div = 1'b1;
      issue_opA    = 32'd1;
      issue_opB    = 32'd2;
      issue_rd     = 5'd8;
      e.rd = 5'd30;
      e.data = 32'd6;
      e.exc = 1'b1;
      sb.push_back(e);
      data_resultRDY = 1'b0;
      for (int unsigned i = 0; i < 50; i++) begin
        @(negedge clock);
        check("to_stall", 32'(stall), 32'd1);
        check("to_wb_early", 32'(wb_valid), 32'd0);
        drive_junk(1'b1);
      end
      @(negedge clock);
      check("to_wb_valid", 32'(wb_valid), 32'd1);
      check_wb();
      issue_valid = 1'b0;
      @(negedge clock);
      check("to_stall_drop", 32'(stall), 32'd0);
    end
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
